multi_digit_display: RTL
========================

MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent numeric channels.
REQ-002 Parameter DIGITS, default 4: decimal digits per channel.
REQ-003 Parameter NUM_WIDTH, default 13: binary width of each channel value.
REQ-004 Parameter DIV_BITS, default 17: per-digit dwell is 2^DIV_BITS Clk cycles.
REQ-005 Clk  input  1  single system clock; all state on its rising edge.
REQ-006 Rst  input  1  asynchronous, active-high reset.
REQ-007 Numbers  input  NUM_CH*NUM_WIDTH  packed channel values; channel c occupies bits [c*NUM_WIDTH +: NUM_WIDTH].
REQ-008 Load  input  1  one-cycle strobe requesting capture and conversion of Numbers.
REQ-009 BlankLZ  input  1  when high, leading zeros are blanked.
REQ-010 out7  output  7  registered, active-low segments; out7[6]=a ... out7[0]=g.
REQ-011 en_out  output  NUM_CH*DIGITS  registered, active-low one-cold digit enables; bit c*DIGITS+d = channel c, digit d (d=0 least significant).
REQ-012 Busy  output  1  high while a conversion is in progress.

Function
REQ-013 Conversion FSM SHALL have states IDLE, CONV, COMMIT.
REQ-014 IDLE: Load=1 SHALL capture all Numbers into a shadow register, clear the channel index, and enter CONV; Busy SHALL be high from the next cycle.
REQ-015 CONV: each channel SHALL take exactly NUM_WIDTH shift-add-3 (double-dabble) cycles, channels in order 0..NUM_CH-1; after the last channel the FSM SHALL enter COMMIT.
REQ-016 COMMIT: all channel digit registers SHALL update atomically in one cycle, Busy SHALL fall, FSM SHALL return to IDLE; Load-to-Busy-low latency is fixed at NUM_CH*NUM_WIDTH+1 cycles.
REQ-017 A channel value >= 10^DIGITS SHALL be overflow: all its digits display code DASH (segment g only) instead of converted digits; conversion cycle count is unchanged.
REQ-018 Load asserted while Busy SHALL set a one-deep pending flag; additional Loads while pending is set are merged.
REQ-019 COMMIT with pending set SHALL clear pending and go directly to CONV, capturing Numbers in that cycle; Busy stays high.
REQ-020 With BlankLZ=1, every zero digit more significant than the most significant nonzero digit SHALL display BLANK (all segments off); a value of 0 SHALL show a single 0 at digit 0; overflow channels are unaffected.
REQ-021 BlankLZ SHALL be applied combinationally at scan time from committed digits, taking effect without a new Load.
REQ-022 Refresh divider SHALL count 0..2^DIV_BITS-1 and wrap; on wrap the scan index SHALL advance, wrapping from NUM_CH*DIGITS-1 to 0 (non-power-of-two totals supported).
REQ-023 out7 and en_out SHALL both change on the same Clk edge, one cycle after the scan index changes.
REQ-024 A COMMIT during a dwell SHALL change out7 from the next cycle without disturbing the scan index or divider.
REQ-025 Decoder SHALL map codes 0-9 to digits, DASH and BLANK to fixed patterns, and all other codes to BLANK.

Reset
REQ-026 Rst SHALL force FSM=IDLE, Busy=0, pending=0, divider=0, scan index=0, all committed digits=BLANK, out7=7'b1111111, en_out=all ones.
REQ-027 Rst mid-conversion SHALL abandon the conversion; committed digits SHALL return to BLANK, never partial results.
REQ-028 First enable SHALL assert (en_out bit 0 low) one cycle after Rst deasserts.

Structure
REQ-029 Shared package SHALL hold digit codes (DASH=4'hA, BLANK=4'hF), segment patterns, FSM state encodings, and a function computing 10^DIGITS.
REQ-030 One sub-module, seg7_decode (4-bit code to 7-bit active-low segments), SHALL be instantiated once on the scan path; the double-dabble datapath stays inline.

Verification (NUM_CH=2, DIGITS=4, NUM_WIDTH=14, DIV_BITS=2)
REQ-031 Rst, then no Load -> out7=7'b1111111 on all digits; en_out walks 11111110..01111111 every 4 cycles, wraps.
REQ-032 Numbers A=1234, B=56, BlankLZ=0, Load -> Busy high exactly 29 cycles; scan shows 4,3,2,1,6,5,0,0.
REQ-033 Same values, BlankLZ=1 -> channel B digits 2,3 BLANK; A=0 shows 0 at digit 0, BLANK at digits 1-3.
REQ-034 A=10000, B=9999 -> channel A all DASH (out7=7'b1111110), B shows 9,9,9,9.
REQ-035 Load at cycle 5 of a conversion, Numbers changed to A=7 -> one extra conversion back-to-back, Busy continuous 58 cycles, final display A=7.
REQ-036 Rst asserted cycle 10 of a conversion -> display BLANK, Busy=0; next Load converts normally.

Source files
------------

// File: rtl/multi_digit_display_pkg.sv
// Shared digit codes, segment patterns, conversion FSM states and the overflow limit helper.
// Segments are active-low, bit 6 = a ... bit 0 = g.
package multi_digit_display_pkg;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } convState_e;

  // Smallest value that no longer fits in n decimal digits.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/multi_digit_display_if.sv
// Value-load and display-scan signals of the multi-digit display.
// master = system side driving numbers, slave = the display block.
interface multi_digit_display_if #(
  parameter int NUM_CH    = 2,
  parameter int DIGITS    = 4,
  parameter int NUM_WIDTH = 13
);
  logic [NUM_CH*NUM_WIDTH-1:0] Numbers;
  logic                        Load;
  logic                        BlankLZ;
  logic [6:0]                  out7;
  logic [NUM_CH*DIGITS-1:0]    en_out;
  logic                        Busy;

  modport master (
    output Numbers, Load, BlankLZ,
    input  out7, en_out, Busy
  );

  modport slave (
    input  Numbers, Load, BlankLZ,
    output out7, en_out, Busy
  );
endinterface

// File: rtl/multi_digit_display_seg7_decode.sv
// Digit code to active-low seven-segment pattern; purely combinational.
// Codes other than 0-9 and DASH decode to all segments off.
module seg7_decode
  import multi_digit_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:       seg = SEG_0;
      4'd1:       seg = SEG_1;
      4'd2:       seg = SEG_2;
      4'd3:       seg = SEG_3;
      4'd4:       seg = SEG_4;
      4'd5:       seg = SEG_5;
      4'd6:       seg = SEG_6;
      4'd7:       seg = SEG_7;
      4'd8:       seg = SEG_8;
      4'd9:       seg = SEG_9;
      CODE_DASH:  seg = SEG_DASH;
      CODE_BLANK: seg = SEG_BLANK;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_digit_display.sv
// Multiplexed decimal display: binary channels converted serially by double-dabble, committed atomically,
// then scanned one digit per 2^DIV_BITS cycles; Load during a conversion queues one restart.
module multi_digit_display
  import multi_digit_display_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DIGITS    = 4,
  parameter int NUM_WIDTH = 13,
  parameter int DIV_BITS  = 17
) (
  input logic                  Clk,
  input logic                  Rst,
  multi_digit_display_if.slave bus
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BIT_W = (NUM_WIDTH > 1) ? $clog2(NUM_WIDTH) : 1;
  localparam int BCD_W = 4 * DIGITS;

  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [DIG_W-1:0] LAST_DIG  = DIG_W'(DIGITS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(NUM_WIDTH - 1);
  localparam logic [63:0]      OVF_LIMIT = 64'(pow10(DIGITS));

  convState_e state, nextState;
  logic       pending;
  logic       capture;

  logic [NUM_WIDTH-1:0] shadowCh [NUM_CH];
  logic [NUM_WIDTH-1:0] binSh;
  logic [BCD_W-1:0]     bcd, bcdAdj, bcdNext;
  logic [CH_W-1:0]      chIdx;
  logic [BIT_W-1:0]     bitCnt;
  logic                 bitLast, chLast, chOverflow;

  logic [3:0] stageDig [NUM_CH][DIGITS];
  logic [3:0] dispDig  [NUM_CH][DIGITS];

  logic [DIV_BITS-1:0]      divCnt;
  logic [CH_W-1:0]          scanCh;
  logic [DIG_W-1:0]         scanDig;
  logic [3:0]               scanCode, shownCode;
  logic                     higherNonZero, lzBlank;
  logic [6:0]               segOut, out7Q;
  logic [NUM_CH*DIGITS-1:0] enNext, enQ;

  assign bitLast    = (bitCnt == LAST_BIT);
  assign chLast     = (chIdx == LAST_CH);
  assign chOverflow = (64'(shadowCh[chIdx]) >= OVF_LIMIT);

  // ---------------- conversion FSM ----------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Load) begin
          nextState = ST_CONV;
          capture   = 1'b1;
        end
      end
      ST_CONV: begin
        if (bitLast && chLast) nextState = ST_COMMIT;
      end
      ST_COMMIT: begin
        // A Load arriving in the commit cycle itself restarts just like a queued one.
        if (pending || bus.Load) begin
          nextState = ST_CONV;
          capture   = 1'b1;
        end else begin
          nextState = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                                pending <= 1'b0;
    else if (state == ST_COMMIT)            pending <= 1'b0;
    else if (bus.Load && state != ST_IDLE)  pending <= 1'b1;
  end

  // ---------------- double-dabble datapath ----------------
  always_comb begin
    bcdAdj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[k*4 +: 4] >= 4'd5) bcdAdj[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
    end
    bcdNext = (bcdAdj << 1) | BCD_W'(binSh[NUM_WIDTH-1]);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      binSh  <= '0;
      bcd    <= '0;
      chIdx  <= '0;
      bitCnt <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        shadowCh[c] <= '0;
        for (int d = 0; d < DIGITS; d++) begin
          stageDig[c][d] <= CODE_BLANK;
          dispDig[c][d]  <= CODE_BLANK;
        end
      end
    end else begin
      if (capture) begin
        for (int c = 0; c < NUM_CH; c++) shadowCh[c] <= bus.Numbers[c*NUM_WIDTH +: NUM_WIDTH];
        binSh  <= bus.Numbers[NUM_WIDTH-1:0];
        bcd    <= '0;
        chIdx  <= '0;
        bitCnt <= '0;
      end else if (state == ST_CONV) begin
        binSh  <= binSh << 1;
        bcd    <= bcdNext;
        bitCnt <= bitCnt + BIT_W'(1);
        if (bitLast) begin
          // Overflow channels keep full conversion timing but store dashes.
          for (int d = 0; d < DIGITS; d++)
            stageDig[chIdx][d] <= chOverflow ? CODE_DASH : bcdNext[d*4 +: 4];
          bcd    <= '0;
          bitCnt <= '0;
          if (!chLast) begin
            chIdx <= chIdx + CH_W'(1);
            binSh <= shadowCh[chIdx + CH_W'(1)];
          end
        end
      end
      if (state == ST_COMMIT) begin
        for (int c = 0; c < NUM_CH; c++)
          for (int d = 0; d < DIGITS; d++)
            dispDig[c][d] <= stageDig[c][d];
      end
    end
  end

  // ---------------- refresh scan ----------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      divCnt  <= '0;
      scanCh  <= '0;
      scanDig <= '0;
    end else begin
      divCnt <= divCnt + DIV_BITS'(1);
      if (&divCnt) begin
        if (scanDig == LAST_DIG) begin
          scanDig <= '0;
          scanCh  <= (scanCh == LAST_CH) ? '0 : scanCh + CH_W'(1);
        end else begin
          scanDig <= scanDig + DIG_W'(1);
        end
      end
    end
  end

  // Leading-zero blanking works on committed digits, so BlankLZ acts without reconversion.
  always_comb begin
    scanCode      = dispDig[scanCh][scanDig];
    higherNonZero = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if ((DIG_W'(k) >= scanDig) && (dispDig[scanCh][k] != 4'd0)) higherNonZero = 1'b1;
    end
    lzBlank   = bus.BlankLZ && (scanDig != '0) && !higherNonZero;
    shownCode = lzBlank ? CODE_BLANK : scanCode;
  end

  always_comb begin
    enNext = '1;
    for (int c = 0; c < NUM_CH; c++)
      for (int d = 0; d < DIGITS; d++)
        enNext[c*DIGITS + d] = !((scanCh == CH_W'(c)) && (scanDig == DIG_W'(d)));
  end

  seg7_decode uDecode (
    .code (shownCode),
    .seg  (segOut)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out7Q <= SEG_BLANK;
      enQ   <= '1;
    end else begin
      out7Q <= segOut;
      enQ   <= enNext;
    end
  end

  assign bus.out7   = out7Q;
  assign bus.en_out = enQ;
  assign bus.Busy   = (state != ST_IDLE);

endmodule
